// File: rtl/lane_renderer.sv
// lane_renderer
//   Repaints the visible part of a note lane onto the 160x120 VGA framebuffer.
//   A start request snapshots lane[VISIBLE-1:0] and then streams one pixel per
//   clock (x/y/colour with plot=1) into vga_adapter.
//   Slot 0 is the hit slot at the bottom of the column. Higher slots are drawn
//   progressively higher, so notes appear to fall as the lane shifts right.
//
// Ports
//   clk     system clock
//   resetn  asynchronous, active-high reset
//   start   repaint request, sampled every clock
//   lane    live lane contents, bit 0 = hit slot
//   busy    high while a frame is being drawn
//   done    one-cycle pulse after the last pixel of a frame
//   x, y    pixel coordinates
//   colour  pixel colour
//   plot    framebuffer write strobe; x/y/colour are valid while it is high
module lane_renderer #(
  parameter int         LANE_BITS   = 100,
  parameter int         VISIBLE     = 10,
  parameter int         NOTE_W      = 10,
  parameter int         NOTE_H      = 10,
  parameter int         LANE_X0     = 40,
  parameter logic [2:0] NOTE_COLOUR = 3'b111,
  parameter logic [2:0] HIT_COLOUR  = 3'b010,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [LANE_BITS-1:0] lane,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           x,
  output logic [7:0]           y,
  output logic [2:0]           colour,
  output logic                 plot
);

  localparam int COL_W  = (NOTE_W  > 1) ? $clog2(NOTE_W)  : 1;
  localparam int ROW_W  = (NOTE_H  > 1) ? $clog2(NOTE_H)  : 1;
  localparam int SLOT_W = (VISIBLE > 1) ? $clog2(VISIBLE) : 1;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NOTE_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(NOTE_H - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(VISIBLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic                pending;
  logic [VISIBLE-1:0]  snap;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic [SLOT_W-1:0]   slot;

  logic [7:0]          pix_x;
  logic [7:0]          pix_y;
  logic [2:0]          pix_colour;

  // Lane bits above the visible window are off-screen and intentionally ignored.
  logic                unused_lane_bits;
  assign unused_lane_bits = ^lane[LANE_BITS-1:VISIBLE];

  // Pixel for the current scan position. Slot 0 sits at the bottom of the
  // column, so the slot index is mirrored before scaling to screen rows.
  always_comb begin
    pix_x = 8'(LANE_X0) + 8'(col);
    pix_y = 8'((VISIBLE - 1 - int'(slot)) * NOTE_H) + 8'(row);
    if (snap[slot]) begin
      pix_colour = NOTE_COLOUR;
    end else if (slot == '0) begin
      pix_colour = HIT_COLOUR;
    end else begin
      pix_colour = BG_COLOUR;
    end
  end

  // Control FSM with registered outputs. busy/plot/done follow the state by one
  // cycle: the IDLE->DRAW edge raises busy, every DRAW edge emits one pixel,
  // and the DONE edge emits the done pulse. Any start seen while a frame is in
  // flight (including on the DONE edge) collapses into one follow-up frame.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state   <= IDLE;
      pending <= 1'b0;
      snap    <= '0;
      col     <= '0;
      row     <= '0;
      slot    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      plot    <= 1'b0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          plot <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            snap  <= lane[VISIBLE-1:0];
            col   <= '0;
            row   <= '0;
            slot  <= '0;
            busy  <= 1'b1;
            state <= DRAW;
          end
        end

        DRAW: begin
          done   <= 1'b0;
          busy   <= 1'b1;
          plot   <= 1'b1;
          x      <= pix_x;
          y      <= pix_y;
          colour <= pix_colour;
          if (start) begin
            pending <= 1'b1;
          end
          // Scan order: column fastest, then row, then slot.
          if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) begin
              row <= '0;
              if (slot == SLOT_LAST) begin
                slot  <= '0;
                state <= DONE;
              end else begin
                slot <= slot + 1'b1;
              end
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end

        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          plot <= 1'b0;
          col  <= '0;
          row  <= '0;
          slot <= '0;
          if (pending || start) begin
            pending <= 1'b0;
            snap    <= lane[VISIBLE-1:0];
            state   <= DRAW;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          plot  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lane_renderer.sv
// tb_lane_renderer
//   Directed self-checking bench for lane_renderer with default parameters.
//   Inputs are driven and outputs sampled on the falling clock edge.
//   Cycle c of a frame means the falling edge after rising edge t+c, where
//   rising edge t is the one that samples the start request.
module tb_lane_renderer;

  localparam int LANE_BITS = 100;

  logic                 clk;
  logic                 resetn;
  logic                 start;
  logic [LANE_BITS-1:0] lane;
  logic                 busy;
  logic                 done;
  logic [7:0]           x;
  logic [7:0]           y;
  logic [2:0]           colour;
  logic                 plot;

  int compared   = 0;
  int mismatched = 0;

  lane_renderer dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .lane   (lane),
    .busy   (busy),
    .done   (done),
    .x      (x),
    .y      (y),
    .colour (colour),
    .plot   (plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic [LANE_BITS-1:0] l);
    start = s;
    lane  = l;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Expected colour of a slot given the snapshot taken at frame start.
  function automatic logic [2:0] expColour(input logic [9:0] s, input int sl);
    if (s[sl])       return 3'b111;
    else if (sl == 0) return 3'b010;
    else             return 3'b000;
  endfunction

  // Issue a one-cycle start from idle and check the cycle-0 state.
  task automatic startFrame(input string name, input logic [LANE_BITS-1:0] l);
    applyStimulus(1'b1, l);
    @(negedge clk);
    applyStimulus(1'b0, l);
    checkOutput({name, " c0 busy"}, 32'(busy), 32'd1);
    checkOutput({name, " c0 plot"}, 32'(plot), 32'd0);
  endtask

  // Check all 1000 pixels of a frame plus its done cycle. Optionally changes
  // lane at a given edge, pulses start at edges 100/200/300, and/or raises
  // start for the edge that samples the done cycle.
  task automatic runFrame(input string name, input logic [9:0] expSnap,
                          input int laneAt, input logic [LANE_BITS-1:0] newLane,
                          input bit pulses, input bit doneStart);
    logic                 s;
    logic [LANE_BITS-1:0] l;
    int                   k;
    int                   sl;
    int                   rw;
    int                   cl;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      k  = c - 1;
      cl = k % 10;
      rw = (k / 10) % 10;
      sl = k / 100;
      checkOutput($sformatf("%s px%0d plot", name, k), 32'(plot), 32'd1);
      checkOutput($sformatf("%s px%0d x", name, k), 32'(x), 32'(40 + cl));
      checkOutput($sformatf("%s px%0d y", name, k), 32'(y), 32'((9 - sl) * 10 + rw));
      checkOutput($sformatf("%s px%0d colour", name, k), 32'(colour),
                  32'(expColour(expSnap, sl)));
      s = (pulses && ((c + 1) == 100 || (c + 1) == 200 || (c + 1) == 300)) ||
          (doneStart && (c + 1) == 1001);
      l = ((c + 1) == laneAt) ? newLane : lane;
      applyStimulus(s, l);
    end
    @(negedge clk);
    applyStimulus(1'b0, lane);
    checkOutput({name, " done pulse"}, 32'(done), 32'd1);
    checkOutput({name, " done busy"}, 32'(busy), 32'd0);
    checkOutput({name, " done plot"}, 32'(plot), 32'd0);
  endtask

  // Confirm the block sits idle for n cycles.
  task automatic idleCheck(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s idle%0d done", name, i), 32'(done), 32'd0);
      checkOutput($sformatf("%s idle%0d busy", name, i), 32'(busy), 32'd0);
      checkOutput($sformatf("%s idle%0d plot", name, i), 32'(plot), 32'd0);
    end
  endtask

  initial begin
    logic [LANE_BITS-1:0] laneA;
    logic [LANE_BITS-1:0] laneB;
    logic [LANE_BITS-1:0] laneC;
    logic [LANE_BITS-1:0] laneD;
    int doneSeen;
    int plotSeen;

    laneA = {90'h0, 10'b0000110011};
    laneB = {90'h3, 10'b1100000001};
    laneC = {90'h0, 10'b0111111110};
    laneD = {90'h0, 10'b1010101010};

    // Reset held for three cycles with start asserted.
    resetn = 1'b1;
    applyStimulus(1'b1, {90'h0, 10'b0000000001});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("reset%0d busy", i), 32'(busy), 32'd0);
      checkOutput($sformatf("reset%0d done", i), 32'(done), 32'd0);
      checkOutput($sformatf("reset%0d plot", i), 32'(plot), 32'd0);
      checkOutput($sformatf("reset%0d x", i), 32'(x), 32'd0);
      checkOutput($sformatf("reset%0d y", i), 32'(y), 32'd0);
      checkOutput($sformatf("reset%0d colour", i), 32'(colour), 32'd0);
    end
    resetn = 1'b0;
    applyStimulus(1'b0, lane);
    idleCheck("post-reset", 3);

    // Basic frame, only the hit slot set.
    $display("[TB] basic frame");
    startFrame("basic", {90'h0, 10'b0000000001});
    runFrame("basic", 10'b0000000001, -1, lane, 1'b0, 1'b0);
    idleCheck("basic", 3);

    // Colour map, with a start in the done cycle giving a back-to-back frame
    // from the lane as it stands at that edge.
    $display("[TB] colour map and done-cycle start");
    startFrame("cmap", {90'h0, 10'b1000000010});
    runFrame("cmap", 10'b1000000010, 600, laneC, 1'b0, 1'b1);
    runFrame("cmap2", laneC[9:0], -1, lane, 1'b0, 1'b0);
    idleCheck("cmap2", 3);

    // Snapshot hold: lane goes all ones mid-frame.
    $display("[TB] snapshot hold");
    startFrame("snap", '0);
    runFrame("snap", 10'b0000000000, 50, '1, 1'b0, 1'b0);
    idleCheck("snap", 3);

    // Pending coalescing: three extra starts yield exactly one extra frame.
    $display("[TB] pending coalescing");
    startFrame("pend", laneA);
    runFrame("pend", laneA[9:0], 400, laneB, 1'b1, 1'b0);
    runFrame("pend2", laneB[9:0], -1, lane, 1'b0, 1'b0);
    idleCheck("pend2", 5);

    // Mid-frame reset aborts the frame without a done pulse.
    $display("[TB] mid-frame reset");
    startFrame("abort", laneD);
    for (int c = 1; c < 500; c++) @(negedge clk);
    checkOutput("abort pre plot", 32'(plot), 32'd1);
    resetn = 1'b1;
    #1;
    checkOutput("abort async plot", 32'(plot), 32'd0);
    checkOutput("abort async busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    doneSeen = 0;
    plotSeen = 0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (done) doneSeen++;
      if (plot || busy) plotSeen++;
    end
    checkOutput("abort done count", 32'(doneSeen), 32'd0);
    checkOutput("abort activity count", 32'(plotSeen), 32'd0);
    startFrame("after", laneD);
    runFrame("after", laneD[9:0], -1, lane, 1'b0, 1'b0);
    idleCheck("after", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
